// File: rtl/bram_dp_masked.sv
// True-dual-port RAM with per-bit write masks, an optional output register,
// a zero-fill sweep after reset, and a same-address write merge with a saturating collision counter.
module bram_dp_masked #(
  parameter int DATA_WIDTH     = 4,
  parameter int ADDR_WIDTH     = 12,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [ADDR_WIDTH-1:0] A0,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [DATA_WIDTH-1:0] D0,
  input  logic [DATA_WIDTH-1:0] D1,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic [DATA_WIDTH-1:0] WEM0,
  input  logic [DATA_WIDTH-1:0] WEM1,
  input  logic                  CE0,
  input  logic                  CE1,
  output logic [DATA_WIDTH-1:0] Q0,
  output logic [DATA_WIDTH-1:0] Q1,
  output logic                  BUSY,
  output logic [15:0]           COLL_CNT
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic [DATA_WIDTH-1:0]   rd0_q, rd0_d, rd1_q, rd1_d;
  logic [DATA_WIDTH-1:0]   out0_q, out0_d, out1_q, out1_d;
  logic                    ld0_q, ld0_d, ld1_q, ld1_d;
  logic [15:0]             coll_cnt_q, coll_cnt_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    ce0, ce1, we0, we1, coll;
  logic [DATA_WIDTH-1:0]   old0, old1, wdata0, wdata1;
  logic                    wen0, wen1;
  logic [ADDR_WIDTH-1:0]   waddr0;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ce0        = CE0 && (state_q == S_READY);
    ce1        = CE1 && (state_q == S_READY);
    we0        = ce0 && WE0;
    we1        = ce1 && WE1;
    old0       = mem[A0];
    old1       = mem[A1];
    coll       = we0 && we1 && (A0 == A1);

    // On a collision port 0 carries the merged word and port 1 stays quiet.
    wen0   = we0;
    waddr0 = A0;
    wdata0 = coll ? ((old0 & ~(WEM0 | WEM1)) | (D0 & WEM0) | (D1 & WEM1 & ~WEM0))
                  : ((old0 & ~WEM0) | (D0 & WEM0));
    wen1   = we1 && !coll;
    wdata1 = (old1 & ~WEM1) | (D1 & WEM1);

    if (state_q == S_CLEAR) begin
      wen0       = 1'b1;
      waddr0     = clr_addr_q;
      wdata0     = '0;
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == '1) state_d = S_READY;
    end
    // Reset must never disturb stored contents.
    if (!RSTN) begin
      wen0 = 1'b0;
      wen1 = 1'b0;
    end

    rd0_d      = ce0 ? old0 : rd0_q;
    rd1_d      = ce1 ? old1 : rd1_q;
    ld0_d      = ce0;
    ld1_d      = ce1;
    out0_d     = ld0_q ? rd0_q : out0_q;
    out1_d     = ld1_q ? rd1_q : out1_q;
    coll_cnt_d = (coll && coll_cnt_q != 16'hFFFF) ? coll_cnt_q + 16'd1 : coll_cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      clr_addr_q <= '0;
      rd0_q      <= '0;
      rd1_q      <= '0;
      out0_q     <= '0;
      out1_q     <= '0;
      ld0_q      <= 1'b0;
      ld1_q      <= 1'b0;
      coll_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rd0_q      <= rd0_d;
      rd1_q      <= rd1_d;
      out0_q     <= out0_d;
      out1_q     <= out1_d;
      ld0_q      <= ld0_d;
      ld1_q      <= ld1_d;
      coll_cnt_q <= coll_cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wen0) mem[waddr0] <= wdata0;
    if (wen1) mem[A1]     <= wdata1;
  end

  assign Q0       = (OUT_REG != 0) ? out0_q : rd0_q;
  assign Q1       = (OUT_REG != 0) ? out1_q : rd1_q;
  assign BUSY     = (state_q == S_CLEAR);
  assign COLL_CNT = coll_cnt_q;
endmodule

// File: tb/tb_bram_dp_masked.sv
// Drives a latency-1 and a latency-2 instance with identical directed stimulus and checks both
// every cycle against an array model, plus hand-computed literal expectations.
module tb_bram_dp_masked;
  logic       CLK, RSTN;
  logic [3:0] A0, A1, D0, D1, WEM0, WEM1;
  logic       WE0, WE1, CE0, CE1;
  logic [3:0] q0a, q1a, q0b, q1b;
  logic       busya, busyb;
  logic [15:0] colla, collb;

  int n_tests = 0;
  int n_fail  = 0;

  bram_dp_masked #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut_a (
    .CLK(CLK), .RSTN(RSTN), .A0(A0), .A1(A1), .D0(D0), .D1(D1), .WE0(WE0), .WE1(WE1),
    .WEM0(WEM0), .WEM1(WEM1), .CE0(CE0), .CE1(CE1), .Q0(q0a), .Q1(q1a), .BUSY(busya),
    .COLL_CNT(colla));

  bram_dp_masked #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .OUT_REG(1), .CLEAR_ON_RESET(1)) dut_b (
    .CLK(CLK), .RSTN(RSTN), .A0(A0), .A1(A1), .D0(D0), .D1(D1), .WE0(WE0), .WE1(WE1),
    .WEM0(WEM0), .WEM1(WEM1), .CE0(CE0), .CE1(CE1), .Q0(q0b), .Q1(q1b), .BUSY(busyb),
    .COLL_CNT(collb));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: word array, busy countdown, read-first per port, latency-2 stage, collision count.
  logic [3:0] mm [16];
  logic [3:0] old [16];
  logic [3:0] e_r0, e_r1, e_o0, e_o1;
  logic       e_l0, e_l1, c0, c1;
  int         busy_cnt = 0;
  int         e_coll   = 0;
  bit         live     = 0;

  initial foreach (mm[i]) mm[i] = 4'h0;

  always @(posedge CLK) begin
    if (!RSTN) begin
      busy_cnt = 16;
      e_r0 = 0; e_r1 = 0; e_o0 = 0; e_o1 = 0; e_l0 = 0; e_l1 = 0;
      e_coll = 0;
      live = 1;
    end else begin
      c0 = (busy_cnt == 0) && CE0;
      c1 = (busy_cnt == 0) && CE1;
      old = mm;
      if (e_l0) e_o0 = e_r0;
      if (e_l1) e_o1 = e_r1;
      e_l0 = c0;
      e_l1 = c1;
      if (c0) e_r0 = old[A0];
      if (c1) e_r1 = old[A1];
      if (c0 && WE0 && c1 && WE1 && A0 == A1) begin
        mm[A0] = (old[A0] & ~(WEM0 | WEM1)) | (D0 & WEM0) | (D1 & WEM1 & ~WEM0);
        if (e_coll < 65535) e_coll++;
      end else begin
        if (c1 && WE1) mm[A1] = (old[A1] & ~WEM1) | (D1 & WEM1);
        if (c0 && WE0) mm[A0] = (old[A0] & ~WEM0) | (D0 & WEM0);
      end
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) foreach (mm[i]) mm[i] = 4'h0;
      end
    end
    #1;
    if (live) begin
      chk("q0_lat1", q0a, e_r0);
      chk("q1_lat1", q1a, e_r1);
      chk("q0_lat2", q0b, e_o0);
      chk("q1_lat2", q1b, e_o1);
      chk("busy_a", busya, busy_cnt != 0);
      chk("busy_b", busyb, busy_cnt != 0);
      chk("coll_a", colla, e_coll);
      chk("coll_b", collb, e_coll);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle();
    CE0 = 0; CE1 = 0; WE0 = 0; WE1 = 0;
  endtask

  task automatic wr0(input logic [3:0] a, input logic [3:0] d, input logic [3:0] m);
    CE0 = 1; WE0 = 1; A0 = a; D0 = d; WEM0 = m;
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    while (busya && n < 40) begin
      tick();
      n++;
    end
    idle();
    chk(nm, n, 16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    RSTN = 0; A0 = 0; A1 = 0; D0 = 0; D1 = 0; WEM0 = 0; WEM1 = 0;
    idle();
    tick(); tick();
    chk("rst_q0", q0a, 0);
    chk("rst_busy", busya, 1);
    chk("rst_coll", colla, 0);

    // 1: sweep length, then everything reads back zero
    RSTN = 1;
    count_busy("sweep_len");
    for (int a = 0; a < 16; a++) begin
      CE0 = 1; CE1 = 1; WE0 = 0; WE1 = 0; A0 = 4'(a); A1 = 4'(15 - a);
      tick();
      chk("clear_rd", q0a, 0);
    end
    idle();

    // 2: masked write, read-first return
    wr0(5, 4'hF, 4'hF); tick();
    wr0(5, 4'h0, 4'h3); tick();
    chk("wr_readfirst", q0a, 4'hF);
    WE0 = 0; tick();
    chk("masked_rd", q0a, 4'hC);
    idle();

    // 3: same-address dual write merge
    wr0(7, 4'hA, 4'hC);
    CE1 = 1; WE1 = 1; A1 = 7; D1 = 4'h5; WEM1 = 4'h7;
    tick();
    chk("coll_cnt1", colla, 1);
    idle(); CE0 = 1; A0 = 7; tick();
    chk("coll_merge", q0a, 4'h9);
    idle();

    // 4: write on port 0 while port 1 reads the same word
    wr0(3, 4'h1, 4'hF); tick();
    wr0(3, 4'h6, 4'hF); CE1 = 1; WE1 = 0; A1 = 3; tick();
    chk("rw_old", q1a, 4'h1);
    CE0 = 0; WE0 = 0; tick();
    chk("rw_new", q1a, 4'h6);
    idle();

    // 5: latency-2 instance changes on the second edge and then holds
    wr0(2, 4'hB, 4'hF); tick();
    WE0 = 0; tick();
    chk("lat1_rd", q0a, 4'hB);
    chk("lat2_edge1", q0b, 4'h0);
    idle(); tick();
    chk("lat2_edge2", q0b, 4'hB);
    tick(); tick();
    chk("lat2_hold", q0b, 4'hB);
    chk("lat1_hold", q0a, 4'hB);

    // 6: reset in mid-sweep restarts it; accesses during BUSY are ignored
    wr0(12, 4'hF, 4'hF); tick(); idle();
    RSTN = 0; tick();
    RSTN = 1;
    for (int i = 0; i < 9; i++) tick();
    RSTN = 0; tick();
    RSTN = 1;
    wr0(0, 4'hF, 4'hF);
    CE1 = 1; WE1 = 1; A1 = 12; D1 = 4'h5; WEM1 = 4'hF;
    count_busy("resweep_len");
    CE0 = 1; A0 = 0; CE1 = 1; A1 = 12; tick();
    chk("busy_nowr0", q0a, 0);
    chk("busy_nowr12", q1a, 0);
    chk("coll_after_rst", colla, 0);
    idle(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
